truth_table_sweeper: RTL
========================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 5, cycles each input vector is held before sampling (legal 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a full 8-vector sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate sweep in progress.
REQ-006 exp_table  input  8  expected truth table, bit i = expected f for vector i; sampled on the done cycle.
REQ-007 dut_a  output  3  stimulus to 3-input combinational DUT; bit 2 = MSB input.
REQ-008 dut_f  input  1  DUT output.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse on sweep completion.
REQ-011 table_out  output  8  captured truth table, bit i = dut_f sampled for vector i.
REQ-012 ones_count  output  4  number of 1s in table_out (0..8).
REQ-013 match  output  1  table_out == exp_table; valid from the done cycle until next start.

Function
REQ-014 FSM states: IDLE, SETTLE, DONE; encoding free.
REQ-015 IDLE: start=1 and abort=0 -> SETTLE next edge; same edge dut_a<=0, settle counter<=0, table_out<=0, ones_count<=0, match<=0.
REQ-016 start while busy or in DONE is ignored; no restart or queueing.
REQ-017 SETTLE: counter increments each cycle; dut_a held stable.
REQ-018 SETTLE with counter == SETTLE_CYCLES-1: table_out[dut_a]<=dut_f, ones_count increments if dut_f=1, counter<=0.
REQ-019 On that sample edge: dut_a<7 -> dut_a increments; dut_a==7 -> state DONE, dut_a stays 7.
REQ-020 Each vector held exactly SETTLE_CYCLES cycles; done asserts exactly 8*SETTLE_CYCLES+1 cycles after the start-accept edge.
REQ-021 DONE: done=1 and busy=0 for one cycle; match registered from table_out vs exp_table; next state IDLE; dut_a<=0.
REQ-022 busy=1 exactly in SETTLE.
REQ-023 table_out, ones_count, match retain values in IDLE until the next accepted start.
REQ-024 abort=1 in SETTLE: next edge -> IDLE, dut_a<=0, no done pulse, match stays 0; partial table_out/ones_count retained; sample due that cycle is discarded.
REQ-025 abort in IDLE or DONE has no effect; start and abort both high in IDLE -> stay IDLE.
REQ-026 ones_count saturation impossible by construction (max 8); width 4 mandatory.
REQ-027 dut_f sampled only on REQ-018 edges; changes at other times have no effect.

Reset
REQ-028 rst_n=0 at a clock edge: state IDLE, dut_a=0, counter=0, busy=0, done=0, table_out=0, ones_count=0, match=0.
REQ-029 Reset mid-sweep takes priority over all inputs; no done pulse; first start after release begins a fresh sweep from vector 0.

Verification (SETTLE_CYCLES=5 unless stated)
REQ-030 DUT model f = majority(A); exp_table=8'hE8; pulse start -> dut_a steps 0..7, 5 cycles each; done at cycle 41 after accept; table_out=8'hE8, ones_count=4, match=1.
REQ-031 DUT model f = A2 XOR A1 XOR A0; exp_table=8'h00 -> table_out=8'h96, ones_count=4, match=0.
REQ-032 abort asserted during vector 3 -> IDLE next cycle, busy=0, no done, table_out bits 7:3=0, dut_a=0.
REQ-033 start re-pulsed every cycle during sweep -> single sweep, single done pulse, timing per REQ-020.
REQ-034 rst_n low during vector 5 -> all outputs 0 next edge; new start yields full correct sweep.
REQ-035 SETTLE_CYCLES=1, f=1 constant -> dut_a changes every cycle, done at cycle 9, table_out=8'hFF, ones_count=8.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// Handshake and result bundle between a truth-table sweeper and whatever drives it,
// plus the stimulus/response pair for the 3-input combinational DUT being characterised.
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic [7:0] exp_table;
  logic [2:0] dut_a;
  logic       dut_f;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic [3:0] ones_count;
  logic       match;

  modport master (
    output start,
    output abort,
    output exp_table,
    output dut_f,
    input  dut_a,
    input  busy,
    input  done,
    input  table_out,
    input  ones_count,
    input  match
  );

  modport slave (
    input  start,
    input  abort,
    input  exp_table,
    input  dut_f,
    output dut_a,
    output busy,
    output done,
    output table_out,
    output ones_count,
    output match
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a 3-input combinational DUT through all 8 input vectors, holding each for
// SETTLE_CYCLES cycles, and captures the resulting truth table with a popcount and compare.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  truth_table_sweeper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] settle_cnt;
  logic [2:0] dut_a_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] table_q;
  logic [3:0] ones_q;
  logic       match_q;

  // All outputs come straight from flops so the DUT stimulus never glitches.
  assign bus.dut_a      = dut_a_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.table_out  = table_q;
  assign bus.ones_count = ones_q;
  assign bus.match      = match_q;

  // NOTE: every register here uses <= so all of them see pre-edge values of each other;
  // the sample edge reads dut_a_q to index table_q while also advancing it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= 8'd0;
      dut_a_q    <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      table_q    <= 8'd0;
      ones_q     <= 4'd0;
      match_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state      <= SETTLE;
            busy_q     <= 1'b1;
            dut_a_q    <= 3'd0;
            settle_cnt <= 8'd0;
            table_q    <= 8'd0;
            ones_q     <= 4'd0;
            match_q    <= 1'b0;
          end
        end

        SETTLE: begin
          if (bus.abort) begin
            // Partial results stay visible; the sample due on this edge is dropped.
            state      <= IDLE;
            busy_q     <= 1'b0;
            dut_a_q    <= 3'd0;
            settle_cnt <= 8'd0;
          end else if (settle_cnt == LAST_COUNT) begin
            table_q[dut_a_q] <= bus.dut_f;
            ones_q           <= ones_q + {3'd0, bus.dut_f};
            settle_cnt       <= 8'd0;
            if (dut_a_q == 3'd7) begin
              state  <= DONE;
              busy_q <= 1'b0;
            end else begin
              dut_a_q <= dut_a_q + 3'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end

        DONE: begin
          done_q  <= 1'b1;
          match_q <= (table_q == bus.exp_table);
          dut_a_q <= 3'd0;
          state   <= IDLE;
        end

        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          dut_a_q <= 3'd0;
        end
      endcase
    end
  end

endmodule
